fsm_rx: RTL

Serial receiver FSM: the receiving end of the `tx`/`busy`/`data` transmitter link.
- Watches a single idle-high serial line and detects a start bit.
- Samples DATA_W data bits LSB-first at mid-bit, then checks the stop bit.
- Presents the received word with a one-cycle valid strobe, or flags a framing error.
- Sits between the line input pin/synchroniser and the consuming logic.

---
 rtl/fsm_rx.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fsm_rx.sv
// ============================================================================
// fsm_rx : UART-style serial receiver, 2-flop synchroniser, mid-bit sampling
// Rev 1.0
// ============================================================================
`default_nettype none

module fsm_rx #(
    parameter int DATA_W       = 3,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              busy,
    output logic              frame_err
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BRK   = 3'd4;

    logic              sync1_q, sync2_q;
    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              busy_q, busy_d;
    logic              rx_s;

    assign rx_s = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A start bit that is gone by mid-bit is a glitch.
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) state_d = ST_STOP;
                    else                   idx_d   = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BRK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BRK: begin
                // Line must return high before another start is recognised.
                cnt_d = '0;
                if (rx_s) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign frame_err = ferr_q;

endmodule

`default_nettype wire
